// File: rtl/torq_sched_pkg.sv
// Shared constants, state encoding, tag format and saturation helper for the
// torque calculation scheduler.
package torq_sched_pkg;

  // Default Q-format: Iq (Q15.0) x Kt (Q2.15) -> shift right 15 to get Q15.0 torque
  localparam int                FRAC_SH  = 15;
  localparam logic [17:0]       KT_RESET = 18'h08000;   // 1.0 in Q2.15
  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  // Channel field is sized for the largest supported requester count (8)
  localparam int CH_MAX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [CH_MAX_W-1:0] ch;
  } tag_t;

  typedef struct packed {
    logic        ovf;
    logic [15:0] value;
  } sat_t;

  // Clamp a shifted 48-bit product to signed 16 bits and flag the clamp
  function automatic sat_t sat16(input logic signed [47:0] r);
    sat_t s;
    if (r > 48'sd32767) begin
      s.ovf   = 1'b1;
      s.value = SAT_MAX;
    end else if (r < -48'sd32768) begin
      s.ovf   = 1'b1;
      s.value = SAT_MIN;
    end else begin
      s.ovf   = 1'b0;
      s.value = r[15:0];
    end
    return s;
  endfunction

endpackage

// File: rtl/torq_sched_fifo.sv
// Synchronous show-ahead FIFO: rd_data presents the head entry whenever
// empty is low; pop consumes it. Pushes into a full FIFO are dropped.
module torq_sched_fifo #(
  parameter int  WIDTH = 19,
  parameter int  DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer wrap and occupancy bookkeeping
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an empty count already hides stale entries and keeps this a plain RAM.
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/torq_calc_scheduler.sv
// Round-robin scheduler sharing one external multiplier between N_CH current
// requesters. Computes torque = Iq * Kt >>> FRAC_SH with 16-bit saturation and
// returns channel-tagged results through a credit-protected output FIFO.
module torq_calc_scheduler
  import torq_sched_pkg::state_e, torq_sched_pkg::IDLE, torq_sched_pkg::RUN,
         torq_sched_pkg::DRAIN, torq_sched_pkg::tag_t, torq_sched_pkg::sat_t,
         torq_sched_pkg::sat16, torq_sched_pkg::CH_MAX_W;
#(
  parameter int              N_CH       = 4,
  parameter int              DATA_W     = 16,
  parameter int              KT_W       = 18,
  parameter int              FRAC_SH    = torq_sched_pkg::FRAC_SH,
  parameter int              DSP_LAT    = 4,
  parameter int              FIFO_DEPTH = 8,
  parameter logic [KT_W-1:0] KT_RESET   = torq_sched_pkg::KT_RESET,
  localparam int             CH_W       = $clog2(N_CH),
  localparam int             CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     enable,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_addr,
  input  logic [KT_W-1:0]          cfg_wdata,
  input  logic [N_CH-1:0]          req_valid,
  input  logic [N_CH*DATA_W-1:0]   req_iq,
  output logic [N_CH-1:0]          req_ready,
  output logic [DATA_W-1:0]        dsp_a,
  output logic [KT_W-1:0]          dsp_b,
  input  logic [47:0]              dsp_p,
  output logic                     m_axis_tvalid,
  output logic [31:0]              m_axis_tdata,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic [15:0]              ovf_count
);

  localparam int TAG_STAGES = DSP_LAT + 1;
  localparam int FIFO_W     = CH_MAX_W + 16;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic [KT_W-1:0]   kt_q [N_CH];
  logic [KT_W-1:0]   kt_d [N_CH];
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  tag_t              tag_q [TAG_STAGES];
  tag_t              tag_d [TAG_STAGES];
  logic [DATA_W-1:0] dsp_a_q, dsp_a_d;
  logic [KT_W-1:0]   dsp_b_q, dsp_b_d;
  logic [15:0]       ovf_q, ovf_d;

  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   cand;
  logic              grant_ok;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W:0]    occupancy;
  logic              credit_ok;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_rd_data;
  logic              fifo_push;
  logic [FIFO_W-1:0] fifo_push_data;
  logic              fifo_pop;

  tag_t              cap_tag;
  logic signed [47:0] shifted;
  sat_t              sat_res;

  // Credit: tags still in the multiplier pipe plus queued results must leave
  // room in the FIFO, so every capture is guaranteed a free slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < TAG_STAGES; i++) begin
      inflight = inflight + CNT_W'(tag_q[i].valid);
    end
    occupancy = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight);
    credit_ok = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = last_grant_q + CH_W'(i + 1);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_ok  = grant_found && credit_ok && (state_q == RUN);
    req_ready = grant_ok ? (N_CH'(1) << grant_idx) : '0;
  end

  // Operand registers, tag pipeline, Kt bank and arbiter pointer updates.
  // Operands read kt_q, so a Kt write to the granted channel lands next cycle.
  always_comb begin
    dsp_a_d      = dsp_a_q;
    dsp_b_d      = dsp_b_q;
    last_grant_d = last_grant_q;
    kt_d         = kt_q;
    if (cfg_we) begin
      kt_d[cfg_addr] = cfg_wdata;
    end
    if (grant_ok) begin
      dsp_a_d      = req_iq[grant_idx*DATA_W +: DATA_W];
      dsp_b_d      = kt_q[grant_idx];
      last_grant_d = grant_idx;
    end
    tag_d[0].valid = grant_ok;
    tag_d[0].ch    = CH_MAX_W'(grant_idx);
    for (int i = 1; i < TAG_STAGES; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Capture: the tag leaving the last stage lines up with the valid product
  always_comb begin
    cap_tag        = tag_q[TAG_STAGES-1];
    shifted        = $signed(dsp_p) >>> FRAC_SH;
    sat_res        = sat16(shifted);
    fifo_push      = cap_tag.valid;
    fifo_push_data = {cap_tag.ch, sat_res.value};
    ovf_d          = ovf_q;
    if (fifo_push && sat_res.ovf && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  // Next-state logic for the run/drain controller
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if ((inflight == '0) && fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, datapath and configuration registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      last_grant_q <= CH_W'(N_CH - 1);
      dsp_a_q      <= '0;
      dsp_b_q      <= '0;
      ovf_q        <= '0;
      for (int i = 0; i < N_CH; i++) begin
        kt_q[i] <= KT_RESET;
      end
      for (int i = 0; i < TAG_STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      dsp_a_q      <= dsp_a_d;
      dsp_b_q      <= dsp_b_d;
      ovf_q        <= ovf_d;
      kt_q         <= kt_d;
      tag_q        <= tag_d;
    end
  end

  assign fifo_pop = m_axis_tvalid && m_axis_tready;

  torq_sched_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = {{(32 - FIFO_W){1'b0}}, fifo_rd_data};
  assign dsp_a         = dsp_a_q;
  assign dsp_b         = dsp_b_q;
  assign busy          = busy_q;
  assign ovf_count     = ovf_q;

endmodule
